// File: rtl/uc_multiciclo.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a bounded memory-wait timeout.
// Define UC_ADDI_EN to add addi support (states ADDI_EXEC/ADDI_WB); otherwise opcode 001000 is illegal.
module uc_multiciclo #(
    parameter int OPW      = 6,
    parameter int AOPW     = 2,
    parameter int WAIT_MAX = 16,
    parameter int CNTW     = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  opcode,
    input  logic            memReady,
    output logic            pcWrite,
    output logic            pcWriteCond,
    output logic            iorD,
    output logic            memRead,
    output logic            memWrite,
    output logic            irWrite,
    output logic            memtoReg,
    output logic            regDst,
    output logic            regWrite,
    output logic            aluSrcA,
    output logic [1:0]      aluSrcB,
    output logic [AOPW-1:0] aluOp,
    output logic [1:0]      pcSrc,
    output logic [3:0]      state,
    output logic            illegal,
    output logic            timeout
);

    typedef enum logic [3:0] {
        RST_ST    = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_RD    = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WR    = 4'd6,
        R_EXEC    = 4'd7,
        R_WB      = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        ADDI_EXEC = 4'd11,
        ADDI_WB   = 4'd12
    } state_t;

    localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
`ifdef UC_ADDI_EN
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
`endif

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            isMemState;
    logic            waitExpired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_ST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign isMemState  = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign waitExpired = isMemState && !memReady && (cnt_q == CNTW'(WAIT_MAX - 1));
    assign state       = state_q;

    // The counter only survives while a memory state keeps waiting; every other path lands at zero,
    // which also clears it on entry to the next memory state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memtoReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = '0;
        pcSrc       = 2'b00;
        illegal     = 1'b0;
        timeout     = 1'b0;

        if (isMemState && !memReady && !waitExpired)
            cnt_d = cnt_q + CNTW'(1);

        case (state_q)
            RST_ST: state_d = FETCH;
            FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
                if (memReady) begin
                    state_d = DECODE;
                end else if (waitExpired) begin
                    timeout = 1'b1;
                    state_d = FETCH;
                end
            end
            DECODE: begin
                aluSrcB = 2'b11;
                case (opcode)
                    OP_R:         state_d = R_EXEC;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
`ifdef UC_ADDI_EN
                    OP_ADDI:      state_d = ADDI_EXEC;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                if (memReady) begin
                    state_d = MEM_WB;
                end else if (waitExpired) begin
                    timeout = 1'b1;
                    state_d = FETCH;
                end
            end
            MEM_WB: begin
                memtoReg = 1'b1;
                regWrite = 1'b1;
                state_d  = FETCH;
            end
            MEM_WR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                if (memReady) begin
                    state_d = FETCH;
                end else if (waitExpired) begin
                    timeout = 1'b1;
                    state_d = FETCH;
                end
            end
            R_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = AOPW'(2'b10);
                state_d = R_WB;
            end
            R_WB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = AOPW'(2'b01);
                pcWriteCond = 1'b1;
                pcSrc       = 2'b01;
                state_d     = FETCH;
            end
            JUMP: begin
                pcWrite = 1'b1;
                pcSrc   = 2'b10;
                state_d = FETCH;
            end
`ifdef UC_ADDI_EN
            ADDI_EXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = ADDI_WB;
            end
            ADDI_WB: begin
                regWrite = 1'b1;
                state_d  = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Self-checking bench for uc_multiciclo: directed vector table, hand-written reset/timeout sequences,
// and randomized instruction streams checked against an instruction-level route model.
module tb_uc_multiciclo;

    localparam int WAIT_MAX = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic       memReady = 1'b0;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memtoReg, regDst, regWrite, aluSrcA, illegal, timeout;
    logic [1:0] aluSrcB, aluOp, pcSrc;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    int route[$];

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        int         st;
        logic       ill;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    uc_multiciclo #(.OPW(6), .AOPW(2), .WAIT_MAX(WAIT_MAX), .CNTW(5)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
        .memWrite(memWrite), .irWrite(irWrite), .memtoReg(memtoReg), .regDst(regDst),
        .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSrc(pcSrc), .state(state), .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Bit order: pcWrite pcWriteCond iorD memRead memWrite irWrite memtoReg regDst regWrite
    // aluSrcA aluSrcB[1:0] aluOp[1:0] pcSrc[1:0] illegal timeout
    function automatic logic [17:0] ctlFor(input int st, input logic rdy);
        logic [17:0] c;
        c = '0;
        case (st)
            1:  begin c[17] = rdy; c[14] = 1'b1; c[12] = rdy; c[7:6] = 2'b01; end
            2:  c[7:6] = 2'b11;
            3:  begin c[8] = 1'b1; c[7:6] = 2'b10; end
            4:  begin c[15] = 1'b1; c[14] = 1'b1; end
            5:  begin c[11] = 1'b1; c[9] = 1'b1; end
            6:  begin c[15] = 1'b1; c[13] = 1'b1; end
            7:  begin c[8] = 1'b1; c[5:4] = 2'b10; end
            8:  begin c[10] = 1'b1; c[9] = 1'b1; end
            9:  begin c[16] = 1'b1; c[8] = 1'b1; c[5:4] = 2'b01; c[3:2] = 2'b01; end
            10: begin c[17] = 1'b1; c[3:2] = 2'b10; end
            11: begin c[8] = 1'b1; c[7:6] = 2'b10; end
            12: c[9] = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic void buildRoute(input logic [5:0] op);
        route.delete();
        route.push_back(1);
        route.push_back(2);
        case (op)
            6'b000000: begin route.push_back(7); route.push_back(8); end
            6'b100011: begin route.push_back(3); route.push_back(4); route.push_back(5); end
            6'b101011: begin route.push_back(3); route.push_back(6); end
            6'b000100: route.push_back(9);
            6'b000010: route.push_back(10);
`ifdef UC_ADDI_EN
            6'b001000: begin route.push_back(11); route.push_back(12); end
`endif
            default: ;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic rdy);
        opcode   = op;
        memReady = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input int expSt, input logic [17:0] expCtl);
        logic [17:0] act;
        act = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memtoReg, regDst,
               regWrite, aluSrcA, aluSrcB, aluOp, pcSrc, illegal, timeout};
        checks++;
        if (state !== 4'(expSt) || act !== expCtl) begin
            errors++;
            $display("[TB] FAIL %s: got state=%0d ctl=%h, want state=%0d ctl=%h",
                     name, state, act, expSt, expCtl);
        end
    endtask

    task automatic addVec(input logic [5:0] op, input logic rdy, input int st, input logic ill);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st; v.ill = ill; v.to = 1'b0;
        vecs.push_back(v);
    endtask

    initial begin
        logic [17:0] exp;
        logic [5:0]  op;
        logic        rdy, isMem, toExp, illExp, aborted;
        int          lowPct, st;

        // R-type, lw with two MEM_RD stalls, sw, beq with a FETCH stall, j, unsupported opcode, addi
        addVec(6'd0, 1, 1, 0);  addVec(6'd0, 1, 2, 0);  addVec(6'd0, 1, 7, 0);  addVec(6'd0, 1, 8, 0);
        addVec(6'd35, 1, 1, 0); addVec(6'd35, 1, 2, 0); addVec(6'd35, 1, 3, 0); addVec(6'd35, 0, 4, 0);
        addVec(6'd35, 0, 4, 0); addVec(6'd35, 1, 4, 0); addVec(6'd35, 1, 5, 0);
        addVec(6'd43, 1, 1, 0); addVec(6'd43, 1, 2, 0); addVec(6'd43, 1, 3, 0); addVec(6'd43, 1, 6, 0);
        addVec(6'd4, 0, 1, 0);  addVec(6'd4, 1, 1, 0);  addVec(6'd4, 1, 2, 0);  addVec(6'd4, 1, 9, 0);
        addVec(6'd2, 1, 1, 0);  addVec(6'd2, 1, 2, 0);  addVec(6'd2, 1, 10, 0);
        addVec(6'h3F, 1, 1, 0); addVec(6'h3F, 1, 2, 1);
        addVec(6'd8, 1, 1, 0);
`ifdef UC_ADDI_EN
        addVec(6'd8, 1, 2, 0);  addVec(6'd8, 1, 11, 0); addVec(6'd8, 1, 12, 0);
`else
        addVec(6'd8, 1, 2, 1);
`endif

        #1;
        checkOutput("reset_state", 0, '0);
        @(posedge clk);
        #1;
        checkOutput("reset_held", 0, '0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].rdy);
            exp = ctlFor(vecs[i].st, vecs[i].rdy);
            exp[1] = vecs[i].ill;
            exp[0] = vecs[i].to;
            checkOutput($sformatf("vec%0d", i), vecs[i].st, exp);
            tick();
        end

        // FETCH starved of memReady: timeout on the 16th cycle, then a retry that succeeds on its 16th
        for (int c = 0; c < WAIT_MAX; c++) begin
            applyStimulus(6'd2, 1'b0);
            exp = ctlFor(1, 1'b0);
            exp[0] = (c == WAIT_MAX - 1);
            checkOutput($sformatf("fetch_to%0d", c), 1, exp);
            tick();
        end
        for (int c = 0; c < WAIT_MAX; c++) begin
            rdy = (c == WAIT_MAX - 1);
            applyStimulus(6'd2, rdy);
            checkOutput($sformatf("fetch_late%0d", c), 1, ctlFor(1, rdy));
            tick();
        end
        applyStimulus(6'd2, 1'b1);
        checkOutput("late_decode", 2, ctlFor(2, 1'b1));
        tick();
        checkOutput("late_jump", 10, ctlFor(10, 1'b1));
        tick();

        // Asynchronous reset in the middle of R_EXEC
        applyStimulus(6'd0, 1'b1);
        checkOutput("pre_rst_fetch", 1, ctlFor(1, 1'b1));
        tick();
        checkOutput("pre_rst_decode", 2, ctlFor(2, 1'b1));
        tick();
        checkOutput("pre_rst_rexec", 7, ctlFor(7, 1'b1));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async", 0, '0);
        tick();
        checkOutput("rst_hold", 0, '0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_fetch", 1, ctlFor(1, 1'b1));
        tick();
        foreach (route[i]) route.delete(i);
        checkOutput("post_rst_decode", 2, ctlFor(2, 1'b1));
        tick();
        checkOutput("post_rst_rexec", 7, ctlFor(7, 1'b1));
        tick();
        checkOutput("post_rst_rwb", 8, ctlFor(8, 1'b1));
        tick();

        // Random instruction stream; each instruction walks its state route, memory steps wait on memReady
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 6))
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b000010;
                5: op = 6'b001000;
                default: op = 6'($urandom);
            endcase
            lowPct = ($urandom_range(0, 3) == 0) ? 90 : 15;
            buildRoute(op);
            aborted = 1'b0;
            for (int i = 0; i < route.size() && !aborted; i++) begin
                st = route[i];
                isMem = (st == 1) || (st == 4) || (st == 6);
                for (int c = 0; c < WAIT_MAX; c++) begin
                    rdy = ($urandom_range(0, 99) >= lowPct);
                    applyStimulus(op, rdy);
                    toExp  = isMem && !rdy && (c == WAIT_MAX - 1);
                    illExp = (st == 2) && (route.size() == 2);
                    exp = ctlFor(st, rdy);
                    exp[1] = illExp;
                    exp[0] = toExp;
                    checkOutput($sformatf("rand%0d_op%0h_st%0d", n, op, st), st, exp);
                    tick();
                    if (!isMem || rdy) break;
                    if (toExp) begin
                        aborted = 1'b1;
                        break;
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
